// File: rtl/wb_cp0_stage_pkg.sv
// rtl/wb_cp0_stage_pkg.sv - shared widths, CP0 addresses, exception codes and WB bus layout
package wb_cp0_stage_pkg;
  localparam int MS_TO_WS_BUS_WD = 116;
  localparam int WS_TO_RF_BUS_WD = 38;

  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Only BEV survives the reset mask; it is hardwired from then on.
  localparam logic [31:0] STATUS_RESET = 32'h00400000;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic        ex;
    logic [4:0]  ex_code;
    logic        mtc0;
    logic [4:0]  cp0_addr;
    logic        eret;
    logic        bd;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_INT,
    ACT_EXC,
    ACT_ERET,
    ACT_MTC0
  } wb_action_e;
endpackage

// File: rtl/wb_cp0_stage_cp0_regs.sv
// rtl/wb_cp0_stage_cp0_regs.sv - CP0 register file with Count/Compare timer and interrupt request
module cp0_regs
  import wb_cp0_stage_pkg::*;
#(
  parameter int HW_INT_N  = 6,
  parameter int COUNT_DIV = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [HW_INT_N-1:0] hw_int,
  input  logic                exc_take,
  input  logic                exc_int,
  input  logic [4:0]          exc_code,
  input  logic                exc_bd,
  input  logic [31:0]         exc_pc,
  input  logic [31:0]         exc_badvaddr,
  input  logic                eret_take,
  input  logic                mtc0_we,
  input  logic [4:0]          mtc0_addr,
  input  logic [31:0]         mtc0_wdata,
  input  logic [4:0]          mfc0_raddr,
  output logic [31:0]         mfc0_rdata,
  output logic [31:0]         epc,
  output logic                int_req
);
  localparam logic [1:0] DIV_LAST = 2'(COUNT_DIV - 1);

  logic [7:0]  im;
  logic        exl, ie;
  logic        bd_q, ti;
  logic [5:0]  hw_ip;
  logic [1:0]  sw_ip;
  logic [4:0]  exc_code_q;
  logic [31:0] badvaddr_q, count_q, compare_q;
  logic [1:0]  div_cnt;
  logic [7:0]  ip;
  logic [31:0] count_inc;
  logic        count_tick, wr_count, wr_compare;

  // The timer shares IP7 with the highest hardware line.
  assign ip         = {hw_ip[5] | ti, hw_ip[4:0], sw_ip};
  assign int_req    = ie && !exl && |(ip & im);
  assign count_tick = (div_cnt == DIV_LAST);
  assign count_inc  = count_q + 32'd1;
  assign wr_count   = mtc0_we && (mtc0_addr == CR_COUNT);
  assign wr_compare = mtc0_we && (mtc0_addr == CR_COMPARE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im         <= '0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      bd_q       <= 1'b0;
      ti         <= 1'b0;
      hw_ip      <= '0;
      sw_ip      <= '0;
      exc_code_q <= '0;
      epc        <= '0;
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      div_cnt    <= '0;
    end else begin
      hw_ip <= 6'(hw_int);

      if (wr_count) begin
        count_q <= mtc0_wdata;
        div_cnt <= '0;
      end else if (count_tick) begin
        count_q <= count_inc;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 2'd1;
      end

      if (wr_compare) begin
        compare_q <= mtc0_wdata;
        ti        <= 1'b0;
      end else if (!wr_count && count_tick && (count_inc == compare_q)) begin
        ti <= 1'b1;
      end

      if (exc_take) begin
        exl        <= 1'b1;
        exc_code_q <= exc_int ? EXC_INT : exc_code;
        // A nested exception keeps the original return point.
        if (!exl) begin
          bd_q <= exc_bd;
          epc  <= exc_bd ? exc_pc - 32'd4 : exc_pc;
        end
        if (!exc_int && (exc_code == EXC_ADEL || exc_code == EXC_ADES))
          badvaddr_q <= exc_badvaddr;
      end else if (eret_take) begin
        exl <= 1'b0;
      end else if (mtc0_we) begin
        case (mtc0_addr)
          CR_BADVADDR: badvaddr_q <= mtc0_wdata;
          CR_STATUS: begin
            im  <= mtc0_wdata[15:8];
            exl <= mtc0_wdata[1];
            ie  <= mtc0_wdata[0];
          end
          CR_CAUSE: sw_ip <= mtc0_wdata[9:8];
          CR_EPC:   epc   <= mtc0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_raddr)
      CR_BADVADDR: mfc0_rdata = badvaddr_q;
      CR_COUNT:    mfc0_rdata = count_q;
      CR_COMPARE:  mfc0_rdata = compare_q;
      CR_STATUS:   mfc0_rdata = STATUS_RESET | {16'b0, im, 6'b0, exl, ie};
      CR_CAUSE:    mfc0_rdata = {bd_q, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};
      CR_EPC:      mfc0_rdata = epc;
      default:     mfc0_rdata = '0;
    endcase
  end
endmodule

// File: rtl/wb_cp0_stage.sv
// rtl/wb_cp0_stage.sv - writeback stage: RF write, trace, exception/eret/mtc0 dispatch to CP0
module wb_cp0_stage
  import wb_cp0_stage_pkg::*;
#(
  parameter int          HW_INT_N  = 6,
  parameter logic [31:0] EX_VECTOR = 32'hBFC00380,
  parameter int          COUNT_DIV = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata,
  output logic [4:0]                 ws_dest,
  output logic [31:0]                ws_dest_data,
  input  logic [HW_INT_N-1:0]        hw_int,
  output logic                       ws_flush,
  output logic [31:0]                ws_flush_pc,
  input  logic [4:0]                 mfc0_raddr,
  output logic [31:0]                mfc0_rdata
);
  ms_to_ws_t   ws_bus;
  logic        ws_valid;
  wb_action_e  action;
  logic        int_req, rf_we, exc_take, eret_take;
  logic [31:0] epc;

  assign ws_allowin = 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
      ws_bus   <= '0;
    end else begin
      if (ws_flush)        ws_valid <= 1'b0;
      else if (ws_allowin) ws_valid <= ms_to_ws_valid;
      if (ms_to_ws_valid && ws_allowin) ws_bus <= ms_to_ws_bus;
    end
  end

  // Exactly one action per instruction; an interrupt pre-empts whatever sits in WB.
  always_comb begin
    action = ACT_NONE;
    if (ws_valid) begin
      if (int_req)            action = ACT_INT;
      else if (ws_bus.ex)     action = ACT_EXC;
      else if (ws_bus.eret)   action = ACT_ERET;
      else if (ws_bus.mtc0)   action = ACT_MTC0;
    end
  end

  assign exc_take    = (action == ACT_INT) || (action == ACT_EXC);
  assign eret_take   = (action == ACT_ERET);
  assign ws_flush    = exc_take || eret_take;
  assign ws_flush_pc = eret_take ? epc : EX_VECTOR;
  assign rf_we       = ws_valid && ws_bus.gr_we && !ws_flush;

  assign ws_to_rf_bus      = {rf_we, ws_bus.dest, ws_bus.result};
  assign debug_wb_pc       = ws_bus.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = ws_bus.dest;
  assign debug_wb_rf_wdata = ws_bus.result;
  assign ws_dest           = ws_bus.dest & {5{ws_valid}};
  assign ws_dest_data      = ws_bus.result;

  cp0_regs #(
    .HW_INT_N (HW_INT_N),
    .COUNT_DIV(COUNT_DIV)
  ) u_cp0_regs (
    .clk         (clk),
    .resetn      (resetn),
    .hw_int      (hw_int),
    .exc_take    (exc_take),
    .exc_int     (action == ACT_INT),
    .exc_code    (ws_bus.ex_code),
    .exc_bd      (ws_bus.bd),
    .exc_pc      (ws_bus.pc),
    .exc_badvaddr(ws_bus.badvaddr),
    .eret_take   (eret_take),
    .mtc0_we     (action == ACT_MTC0),
    .mtc0_addr   (ws_bus.cp0_addr),
    .mtc0_wdata  (ws_bus.result),
    .mfc0_raddr  (mfc0_raddr),
    .mfc0_rdata  (mfc0_rdata),
    .epc         (epc),
    .int_req     (int_req)
  );
endmodule

// File: tb/tb_wb_cp0_stage.sv
// tb/tb_wb_cp0_stage.sv - bench for wb_cp0_stage: vector table, directed timer/wrap/reset cases, random vs model
module tb_wb_cp0_stage;
  import wb_cp0_stage_pkg::*;

  localparam int          HW_N  = 6;
  localparam int          DIV   = 2;
  localparam logic [31:0] EXV   = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ms_to_ws_valid = 1'b0;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus = '0;
  logic        ws_allowin;
  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata, ws_dest_data, ws_flush_pc, mfc0_rdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum, ws_dest;
  logic [HW_N-1:0] hw_int = '0;
  logic        ws_flush;
  logic [4:0]  mfc0_raddr = '0;

  always #5 clk = ~clk;

  wb_cp0_stage #(.HW_INT_N(HW_N), .EX_VECTOR(EXV), .COUNT_DIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ws_allowin(ws_allowin), .ws_to_rf_bus(ws_to_rf_bus), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .ws_dest(ws_dest), .ws_dest_data(ws_dest_data),
    .hw_int(hw_int), .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc),
    .mfc0_raddr(mfc0_raddr), .mfc0_rdata(mfc0_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model of the WB slot and CP0, kept as plain fields.
  bit          m_valid;
  ms_to_ws_t   m_inst;
  bit [7:0]    m_im;
  bit          m_exl, m_ie, m_bd, m_ti;
  bit [1:0]    m_sw;
  bit [5:0]    m_hw;
  bit [4:0]    m_exc;
  bit [31:0]   m_epc, m_bad, m_cmp, m_base;
  longint      m_ticks;
  logic [5:0]  cur_hw = '0;
  logic [4:0]  rd_addr = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    m_valid = 0; m_inst = '0; m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
    m_sw = 0; m_hw = 0; m_exc = 0; m_epc = 0; m_bad = 0; m_cmp = 0; m_base = 0; m_ticks = 0;
  endfunction

  // Count is the last written base plus whole divider periods elapsed since.
  function automatic bit [31:0] m_count();
    longint t;
    t = longint'(m_base) + m_ticks / longint'(DIV);
    return t[31:0];
  endfunction

  function automatic bit [7:0] m_ip();
    bit [7:0] v;
    v = {6'b0, m_sw} | (8'(m_hw) << 2);
    if (m_ti) v[7] = 1'b1;
    return v;
  endfunction

  function automatic bit [31:0] m_read(bit [4:0] a);
    case (a)
      5'd8:  return m_bad;
      5'd9:  return m_count();
      5'd11: return m_cmp;
      5'd12: return 32'h00400000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // 0 none, 1 interrupt, 2 exception, 3 eret, 4 mtc0
  function automatic int m_action();
    if (!m_valid) return 0;
    if (m_ie && !m_exl && ((m_ip() & m_im) != 0)) return 1;
    if (m_inst.ex)   return 2;
    if (m_inst.eret) return 3;
    if (m_inst.mtc0) return 4;
    return 0;
  endfunction

  function automatic void m_update(int act, bit v, ms_to_ws_t b, bit [5:0] hw);
    bit [31:0] old_cnt, new_cnt, wd;
    bit wrc, wrcmp, fl;
    old_cnt = m_count();
    wd = m_inst.result;
    fl = (act == 1) || (act == 2) || (act == 3);
    wrc = (act == 4) && (m_inst.cp0_addr == 5'd9);
    wrcmp = (act == 4) && (m_inst.cp0_addr == 5'd11);
    if (act == 1 || act == 2) begin
      if (!m_exl) begin
        m_bd = m_inst.bd;
        m_epc = m_inst.bd ? m_inst.pc - 32'd4 : m_inst.pc;
      end
      m_exl = 1;
      m_exc = (act == 1) ? 5'd0 : m_inst.ex_code;
      if (act == 2 && (m_inst.ex_code == 5'd4 || m_inst.ex_code == 5'd5)) m_bad = m_inst.badvaddr;
    end else if (act == 3) begin
      m_exl = 0;
    end else if (act == 4) begin
      case (m_inst.cp0_addr)
        5'd8:  m_bad = wd;
        5'd12: begin m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0]; end
        5'd13: m_sw = wd[9:8];
        5'd14: m_epc = wd;
        default: ;
      endcase
    end
    if (wrc) begin m_base = wd; m_ticks = 0; end
    else m_ticks++;
    new_cnt = m_count();
    if (wrcmp) begin m_cmp = wd; m_ti = 0; end
    else if (!wrc && new_cnt != old_cnt && new_cnt == m_cmp) m_ti = 1;
    m_hw = hw;
    m_valid = fl ? 1'b0 : v;
    if (v) m_inst = b;
  endfunction

  // One clock: drive inputs, check combinational outputs against the model mid-cycle, advance model.
  task automatic cycle(input bit v, input ms_to_ws_t b);
    int act;
    bit fl, we;
    ms_to_ws_valid = v;
    ms_to_ws_bus = b;
    mfc0_raddr = rd_addr;
    hw_int = cur_hw;
    @(negedge clk);
    act = m_action();
    fl = (act == 1) || (act == 2) || (act == 3);
    we = m_valid && m_inst.gr_we && !fl;
    chk("m_flush", 32'(ws_flush), 32'(fl));
    if (fl) chk("m_flush_pc", ws_flush_pc, (act == 3) ? m_epc : EXV);
    chk("m_rf_we", 32'(ws_to_rf_bus[37]), 32'(we));
    if (we) chk("m_rf_waddr_wdata", {ws_to_rf_bus[36:32], ws_to_rf_bus[31:5]}, {m_inst.dest, m_inst.result[31:5]});
    chk("m_wen", 32'(debug_wb_rf_wen), we ? 32'hF : 32'h0);
    chk("m_ws_dest", 32'(ws_dest), m_valid ? 32'(m_inst.dest) : 32'h0);
    chk("m_allowin", 32'(ws_allowin), 32'h1);
    chk("m_mfc0", mfc0_rdata, m_read(rd_addr));
    @(posedge clk);
    #1;
    m_update(act, v, b, cur_hw);
  endtask

  task automatic rd_check(input logic [4:0] a, input logic [31:0] exp, input string name);
    rd_addr = a;
    mfc0_raddr = a;
    #1;
    chk(name, mfc0_rdata, exp);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ms_to_ws_valid = 1'b0;
    #1;
    chk("rst_flush", 32'(ws_flush), 32'h0);
    chk("rst_rf_we", 32'(ws_to_rf_bus[37]), 32'h0);
    chk("rst_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("rst_ws_dest", 32'(ws_dest), 32'h0);
    chk("rst_allowin", 32'(ws_allowin), 32'h1);
    rd_check(5'd8,  32'h0, "rst_badvaddr");
    rd_check(5'd9,  32'h0, "rst_count");
    rd_check(5'd11, 32'h0, "rst_compare");
    rd_check(5'd12, 32'h00400000, "rst_status");
    rd_check(5'd13, 32'h0, "rst_cause");
    rd_check(5'd14, 32'h0, "rst_epc");
    m_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  function automatic ms_to_ws_t mk(bit ex, bit [4:0] code, bit mt, bit [4:0] addr, bit er, bit bd,
                                   bit we, bit [4:0] dest, bit [31:0] res, bit [31:0] pc, bit [31:0] bad);
    ms_to_ws_t b;
    b = '0;
    b.ex = ex; b.ex_code = code; b.mtc0 = mt; b.cp0_addr = addr; b.eret = er; b.bd = bd;
    b.gr_we = we; b.dest = dest; b.result = res; b.pc = pc; b.badvaddr = bad;
    return b;
  endfunction

  function automatic ms_to_ws_t rand_inst();
    ms_to_ws_t b;
    bit [4:0] al [7];
    int r;
    al = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    b = '0;
    b.pc = $urandom & 32'hFFFFFFFC;
    b.badvaddr = $urandom;
    b.bd = 1'($urandom);
    b.gr_we = 1'($urandom);
    b.dest = 5'($urandom);
    b.result = $urandom;
    r = $urandom_range(0, 99);
    if (r < 8) begin
      b.ex = 1'b1;
      case ($urandom_range(0, 3))
        0: b.ex_code = 5'd4;
        1: b.ex_code = 5'd5;
        2: b.ex_code = 5'd12;
        default: b.ex_code = 5'($urandom);
      endcase
    end else if (r < 16) begin
      b.eret = 1'b1;
    end else if (r < 45) begin
      b.mtc0 = 1'b1;
      b.cp0_addr = al[$urandom_range(0, 6)];
      if ($urandom_range(0, 1) == 1) b.result = 32'($urandom_range(0, 40));
    end
    if ($urandom_range(0, 9) == 0) b.eret = 1'b1;
    if ($urandom_range(0, 9) == 0) b.mtc0 = 1'b1;
    return b;
  endfunction

  typedef struct {
    string      name;
    bit         v;
    ms_to_ws_t  b;
    bit         e_flush;
    logic [31:0] e_fpc;
    bit         e_we;
    logic [4:0] e_dest;
    logic [4:0] chk_addr;   // read after the vector lands in WB: shows the previous vector's CP0 effect
    logic [31:0] chk_val;
  } vec_t;

  vec_t tbl [8];

  initial begin
    bit seen, moved;
    logic [31:0] prev;

    tbl[0] = '{"add_r5", 1, mk(0,0,0,0,0,0,1,5'd5,32'h1234,32'hBFC00000,0), 0, 0, 1, 5'd5, 5'd12, 32'h00400000};
    tbl[1] = '{"adel_bd", 1, mk(1,5'd4,0,0,0,1,1,5'd3,32'h9,32'hBFC00100,32'h3), 1, EXV, 0, 5'd3, 5'd8, 32'h0};
    tbl[2] = '{"drop_after_exc", 1, mk(0,0,0,0,0,0,1,5'd9,32'h77,32'hBFC00104,0), 0, 0, 0, 5'd0, 5'd14, 32'hBFC000FC};
    tbl[3] = '{"mtc0_epc", 1, mk(0,0,1,5'd14,0,0,0,5'd0,32'hBFC00200,32'hBFC00108,0), 0, 0, 0, 5'd0, 5'd8, 32'h3};
    tbl[4] = '{"eret", 1, mk(0,0,0,0,1,0,1,5'd4,32'h5,32'hBFC0010C,0), 1, 32'hBFC00200, 0, 5'd4, 5'd12, 32'h00400002};
    tbl[5] = '{"drop_after_eret", 1, mk(0,0,0,0,0,0,1,5'd6,32'h66,32'hBFC00110,0), 0, 0, 0, 5'd0, 5'd12, 32'h00400000};
    tbl[6] = '{"add_r6", 1, mk(0,0,0,0,0,0,1,5'd6,32'h66,32'hBFC00200,0), 0, 0, 1, 5'd6, 5'd13, 32'h80000010};
    tbl[7] = '{"bubble", 0, '0, 0, 0, 0, 5'd0, 5'd14, 32'hBFC00200};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].v, tbl[i].b);
      chk({tbl[i].name, "_flush"}, 32'(ws_flush), 32'(tbl[i].e_flush));
      if (tbl[i].e_flush) chk({tbl[i].name, "_flush_pc"}, ws_flush_pc, tbl[i].e_fpc);
      chk({tbl[i].name, "_we"}, 32'(ws_to_rf_bus[37]), 32'(tbl[i].e_we));
      if (tbl[i].e_we) chk({tbl[i].name, "_rf_bus"}, ws_to_rf_bus[31:0], tbl[i].b.result);
      chk({tbl[i].name, "_ws_dest"}, 32'(ws_dest), 32'(tbl[i].e_dest));
      rd_check(tbl[i].chk_addr, tbl[i].chk_val, {tbl[i].name, "_cp0"});
    end

    // Timer interrupt: Compare=10, IE with IM7, wait for TI then present one instruction.
    do_reset();
    rd_addr = 5'd0;
    cycle(1, mk(1,5'd12,0,0,0,0,0,0,0,32'h80000000,0));
    cycle(0, '0);
    cycle(1, mk(0,0,1,5'd12,0,0,0,0,32'h00008001,32'h80000004,0));
    cycle(1, mk(0,0,1,5'd11,0,0,0,0,32'd10,32'h80000008,0));
    rd_addr = 5'd13;
    seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      cycle(0, '0);
      mfc0_raddr = 5'd13;
      #1;
      seen = mfc0_rdata[30];
    end
    chk("ti_seen", 32'(seen), 32'h1);
    rd_check(5'd9, 32'd10, "ti_count_at_set");
    cycle(1, mk(0,0,0,0,0,0,1,5'd2,32'h42,32'h80000040,0));
    chk("int_flush", 32'(ws_flush), 32'h1);
    chk("int_flush_pc", ws_flush_pc, EXV);
    chk("int_we", 32'(ws_to_rf_bus[37]), 32'h0);
    cycle(0, '0);
    rd_check(5'd13, 32'h40008000, "int_cause");
    rd_check(5'd14, 32'h80000040, "int_epc");

    // Count write coinciding with a divider tick, then wrap to zero.
    rd_addr = 5'd9;
    mfc0_raddr = 5'd9;
    #1;
    prev = mfc0_rdata;
    moved = 0;
    for (int k = 0; k < 10 && !moved; k++) begin
      cycle(0, '0);
      mfc0_raddr = 5'd9;
      #1;
      moved = (mfc0_rdata != prev);
    end
    chk("count_moves", 32'(moved), 32'h1);
    cycle(1, mk(0,0,1,5'd9,0,0,0,0,32'hFFFFFFFF,32'h80000080,0));
    cycle(0, '0);
    rd_check(5'd9, 32'hFFFFFFFF, "count_write_wins");
    cycle(0, '0);
    rd_check(5'd9, 32'hFFFFFFFF, "count_hold");
    cycle(0, '0);
    rd_check(5'd9, 32'h0, "count_wrap");

    // Randomised traffic checked cycle by cycle against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) cur_hw = 6'($urandom);
      case ($urandom_range(0, 6))
        0: rd_addr = 5'd8;
        1: rd_addr = 5'd9;
        2: rd_addr = 5'd11;
        3: rd_addr = 5'd12;
        4: rd_addr = 5'd13;
        5: rd_addr = 5'd14;
        default: rd_addr = 5'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, rand_inst());
    end

    // Reset asserted while an exception sits in WB: no CP0 side effect may survive.
    cur_hw = '0;
    rd_addr = 5'd0;
    cycle(1, mk(1,5'd5,0,0,0,1,1,5'd7,32'h1,32'h80001000,32'hDEAD0001));
    chk("pre_reset_flush", 32'(ws_flush), 32'h1);
    do_reset();
    cycle(0, '0);
    rd_check(5'd14, 32'h0, "post_reset_epc");
    rd_check(5'd8, 32'h0, "post_reset_badvaddr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
